// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter sequencer and its
// return-address stack.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } pc_state_e;

    localparam int DEF_PC_WIDTH  = 4;
    localparam int DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of DEPTH entries with occupancy count.
// Only the count is reset; entry contents are meaningless until pushed.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = DEF_PC_WIDTH,
    parameter int DEPTH = DEF_RAS_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    // Entry i is written when it is the next free slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && count == CNT_W'(i)) begin
                mem[i] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CNT_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with sequential advance, jump, relative branch, call/return
// through a return-address stack, and halt/fault states.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                    PC_WIDTH  = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_VEC = '0,
    parameter int                    STEP      = 1,
    parameter int                    RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic [2:0]                        op,
    input  logic [PC_WIDTH-1:0]               target,
    input  logic                              resume,
    output logic [PC_WIDTH-1:0]               pc_out,
    output logic                              halted,
    output logic                              fault,
    output logic [$clog2(RAS_DEPTH+1)-1:0]    ras_count,
    output logic                              ras_full,
    output logic                              ras_empty
);

    pc_state_e             state, state_nxt;
    logic [PC_WIDTH-1:0]   pc, pc_nxt;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   ras_top;
    logic signed [PC_WIDTH-1:0] br_off;
    logic                  push, pop;

    // Same-width add wraps modulo 2^PC_WIDTH, which is exactly the sign-extended
    // offset add the branch needs.
    assign pc_inc = pc + PC_WIDTH'(STEP);
    assign br_off = signed'(target);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
            pc    <= RESET_VEC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        pop       = 1'b0;
        if (!stall) begin
            case (state)
                ST_RUN: begin
                    case (op)
                        OP_JMP:  pc_nxt = target;
                        OP_BR:   pc_nxt = pc + unsigned'(br_off);
                        OP_CALL: begin
                            if (ras_full) begin
                                state_nxt = ST_FAULT;
                            end else begin
                                push   = 1'b1;
                                pc_nxt = target;
                            end
                        end
                        OP_RET: begin
                            if (ras_empty) begin
                                state_nxt = ST_FAULT;
                            end else begin
                                pop    = 1'b1;
                                pc_nxt = ras_top;
                            end
                        end
                        OP_HALT: state_nxt = ST_HALTED;
                        default: pc_nxt = pc_inc;
                    endcase
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_nxt = ST_RUN;
                        pc_nxt    = pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    pc_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    assign pc_out = pc;
    assign halted = (state == ST_HALTED);
    assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer at PC_WIDTH=4, RAS_DEPTH=2, STEP=1.
module tb_pc_sequencer;

    localparam int W = 4;
    localparam int D = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset, stall, resume;
    logic [2:0]    op;
    logic [W-1:0]  target;
    logic [W-1:0]  pc_out;
    logic          halted, fault, ras_full, ras_empty;
    logic [CW-1:0] ras_count;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer #(
        .PC_WIDTH  (W),
        .RESET_VEC (4'd0),
        .STEP      (1),
        .RAS_DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .op        (op),
        .target    (target),
        .resume    (resume),
        .pc_out    (pc_out),
        .halted    (halted),
        .fault     (fault),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [W-1:0] t);
        op     = o;
        target = t;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; resume = 1'b0; drive(3'd0, 4'd0);
        step();
        chk("rst_pc", 8'(pc_out), 8'd0);
        chk("rst_halted", 8'(halted), 8'd0);
        chk("rst_fault", 8'(fault), 8'd0);
        chk("rst_cnt", 8'(ras_count), 8'd0);
        chk("rst_empty", 8'(ras_empty), 8'd1);
        chk("rst_full", 8'(ras_full), 8'd0);

        reset = 1'b1;
        step(); chk("seq1", 8'(pc_out), 8'd1);
        step(); chk("seq2", 8'(pc_out), 8'd2);
        step(); chk("seq3", 8'(pc_out), 8'd3);
        reset = 1'b0; stall = 1'b1;
        step(); chk("rst_over_stall", 8'(pc_out), 8'd0);
        reset = 1'b1; stall = 1'b0;

        drive(3'd1, 4'd14); step(); chk("jmp14", 8'(pc_out), 8'd14);
        drive(3'd0, 4'd0);  step(); chk("seq15", 8'(pc_out), 8'd15);
        step(); chk("wrap0", 8'(pc_out), 8'd0);
        drive(3'd7, 4'd0);  step(); chk("op7_seq", 8'(pc_out), 8'd1);
        drive(3'd1, 4'd3);  step(); chk("jmp3", 8'(pc_out), 8'd3);
        drive(3'd2, 4'b1110); step(); chk("br_neg2", 8'(pc_out), 8'd1);
        drive(3'd1, 4'd12); step(); chk("jmp12", 8'(pc_out), 8'd12);
        drive(3'd2, 4'b0111); step(); chk("br_p7_wrap", 8'(pc_out), 8'd3);

        drive(3'd1, 4'd7); stall = 1'b1;
        step(); chk("stall1", 8'(pc_out), 8'd3);
        step(); chk("stall2", 8'(pc_out), 8'd3);
        stall = 1'b0;
        step(); chk("jmp7", 8'(pc_out), 8'd7);

        drive(3'd1, 4'd2); step(); chk("jmp2", 8'(pc_out), 8'd2);
        drive(3'd3, 4'd9); step();
        chk("call9_pc", 8'(pc_out), 8'd9);
        chk("call9_cnt", 8'(ras_count), 8'd1);
        drive(3'd3, 4'd4); step();
        chk("call4_pc", 8'(pc_out), 8'd4);
        chk("call4_full", 8'(ras_full), 8'd1);
        drive(3'd4, 4'd0); step();
        chk("ret1_pc", 8'(pc_out), 8'd10);
        chk("ret1_cnt", 8'(ras_count), 8'd1);
        step();
        chk("ret2_pc", 8'(pc_out), 8'd3);
        chk("ret2_empty", 8'(ras_empty), 8'd1);

        drive(3'd3, 4'd9); step();
        drive(3'd3, 4'd4); step();
        chk("refill_cnt", 8'(ras_count), 8'd2);
        drive(3'd3, 4'd1); step();
        chk("ovf_fault", 8'(fault), 8'd1);
        chk("ovf_pc", 8'(pc_out), 8'd4);
        chk("ovf_cnt", 8'(ras_count), 8'd2);
        drive(3'd1, 4'd0); resume = 1'b1; step();
        chk("flt_jmp_pc", 8'(pc_out), 8'd4);
        chk("flt_resume", 8'(fault), 8'd1);
        drive(3'd4, 4'd0); resume = 1'b0; step();
        chk("flt_ret_pc", 8'(pc_out), 8'd4);
        chk("flt_ret_cnt", 8'(ras_count), 8'd2);
        reset = 1'b0; step(); reset = 1'b1;
        chk("flt_clr", 8'(fault), 8'd0);
        chk("flt_clr_cnt", 8'(ras_count), 8'd0);

        drive(3'd4, 4'd0); step();
        chk("unf_fault", 8'(fault), 8'd1);
        chk("unf_pc", 8'(pc_out), 8'd0);
        reset = 1'b0; step(); reset = 1'b1;

        drive(3'd1, 4'd5); step(); chk("jmp5", 8'(pc_out), 8'd5);
        drive(3'd5, 4'd0); step();
        chk("halt_flag", 8'(halted), 8'd1);
        chk("halt_pc", 8'(pc_out), 8'd5);
        drive(3'd0, 4'd0); step(); chk("halt_seq", 8'(pc_out), 8'd5);
        drive(3'd1, 4'd9); step(); chk("halt_jmp", 8'(pc_out), 8'd5);
        stall = 1'b1; resume = 1'b1; step();
        chk("halt_stall", 8'(halted), 8'd1);
        stall = 1'b0; step();
        chk("resume_flag", 8'(halted), 8'd0);
        chk("resume_pc", 8'(pc_out), 8'd6);
        drive(3'd0, 4'd0); step();
        chk("run_resume_ign", 8'(pc_out), 8'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the 4-bit program counter. It holds the fetch address and advances it by a fixed step each enabled cycle. It also supports absolute jumps, PC-relative branches, and call/return through a return-address stack (RAS) of configurable depth, plus halt/resume and fault states. It sits between the control decoder (op, target) and instruction memory (pc_out).

Parameters:
PC_WIDTH, 4, width of the PC, target and offset fields
RESET_VEC, 0, PC value loaded on reset
STEP, 1, sequential increment per advance
RAS_DEPTH, 4, number of return-address stack entries (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset; 0 at a rising edge resets the block
stall  in  1  1 = freeze PC, RAS and state this cycle
op  in  3  0 SEQ, 1 JMP, 2 BR, 3 CALL, 4 RET, 5 HALT, 6/7 treated as SEQ
target  in  PC_WIDTH  absolute address (JMP/CALL) or two's-complement offset (BR)
resume  in  1  leave HALTED state
pc_out  out  PC_WIDTH  current fetch address (registered)
halted  out  1  1 while in HALTED
fault  out  1  1 while in FAULT
ras_count  out  $clog2(RAS_DEPTH+1)  occupied RAS entries
ras_full  out  1  ras_count == RAS_DEPTH
ras_empty  out  1  ras_count == 0

Behaviour:
- Reset (reset=0 at edge): pc_out=RESET_VEC, state=RUN, ras_count=0, halted=0, fault=0. Reset overrides stall, op and resume. RAS contents are don't-care after reset.
- All outputs are registered or decoded from registers. An op sampled at edge N is visible on pc_out after edge N. Latency is 1 cycle.
- Priority per edge: reset > stall > state-specific action.
- stall=1: nothing changes, in any state.
- State RUN, stall=0:
  - SEQ: pc <= pc+STEP.
  - JMP: pc <= target.
  - BR: pc <= pc + sign_extend(target).
  - CALL: if !ras_full, push pc+STEP and pc <= target. If ras_full: FAULT, pc and RAS unchanged.
  - RET: if !ras_empty, pc <= top entry and pop. If ras_empty: FAULT, pc unchanged.
  - HALT: state <= HALTED, pc unchanged.
  - resume is ignored in RUN.
- State HALTED, stall=0:
  - resume=1: state <= RUN and pc <= pc+STEP on the same edge.
  - resume=0: hold. op is ignored throughout HALTED.
- State FAULT: pc, RAS and state hold. Only reset exits FAULT.
- Arithmetic: all PC arithmetic is modulo 2^PC_WIDTH. Wrap-around is silent (e.g. 15+1 -> 0 at width 4). BR offset range is -2^(PC_WIDTH-1) .. 2^(PC_WIDTH-1)-1.
- RAS: LIFO. Pushed value is the return address pc+STEP, already wrapped. CALL and RET are never simultaneous, since op is a single field.
- halted = (state==HALTED); fault = (state==FAULT).

Decomposition:
- Shared package pc_pkg holds:
  - op_e enum (OP_SEQ..OP_HALT, 3-bit).
  - pc_state_e enum (RUN, HALTED, FAULT).
  - Default widths.
- Sub-module pc_ras holds the stack storage: push, pop, top, count, full and empty, parametrised by width and depth. pc_sequencer holds the PC register, next-PC mux and FSM.

Test Plan:
All scenarios use PC_WIDTH=4, RAS_DEPTH=2, STEP=1.
- Reset then SEQ x3 -> pc_out 0,1,2,3. Apply reset=0 mid-run while stall=1 -> pc_out=0 next edge.
- SEQ from pc=14 x2 -> 15 then 0 (wrap). BR target=4'b1110 (-2) at pc=3 -> 1. BR target=4'b0111 at pc=12 -> 3.
- JMP 7 with stall=1 for 2 cycles -> pc stays. Release stall -> pc=7 one edge later.
- CALL 9 at pc=2 -> pc=9, ras_count=1. CALL 4 -> pc=4, ras_full=1. RET -> pc=10. RET -> pc=3, ras_empty=1.
- Third CALL with RAS full -> fault=1, pc and ras_count unchanged. Subsequent ops and resume ignored. Reset clears fault.
- RET with RAS empty -> fault=1. Separately: HALT at pc=5 -> halted=1, pc=5 held across SEQ/JMP. resume=1 -> halted=0, pc=6.
